// File: rtl/ex_stage_md.sv
// rtl/ex_stage_md.sv - execute stage with forwarding muxes, single-cycle alu and registered EX/MEM output.
// Define EX_MULDIV_EN to add the iterative MUL/DIVU/REMU engine (IDLE/BUSY/DONE) that stalls the front end.

module alu #(
   parameter int DATA_W = 16
) (
   input  logic [3:0]        op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] result
);
   localparam int SH_W = $clog2(DATA_W);

   logic [SH_W-1:0] shamt;

   always_comb begin
      shamt  = b[SH_W-1:0];
      result = '0;
      case (op)
         4'h0: result = a + b;
         4'h1: result = a - b;
         4'h2: result = a & b;
         4'h3: result = a | b;
         4'h4: result = a ^ b;
         4'h5: result = ~(a | b);
         4'h6: result = {{(DATA_W-1){1'b0}}, $signed(a) < $signed(b)};
         4'h7: result = {{(DATA_W-1){1'b0}}, a < b};
         4'h8: result = a << shamt;
         4'h9: result = a >> shamt;
         4'hA: result = $signed(a) >>> shamt;
         4'hB: result = b;
         default: result = '0;
      endcase
   end
endmodule

module ex_stage_md #(
   parameter int                DATA_W   = 16,
   parameter int                IMM_W    = 6,
   parameter int                REG_AW   = 3,
   parameter logic [REG_AW-1:0] LINK_REG = {REG_AW{1'b1}}
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              flush,
   input  logic [3:0]        alu_op,
   input  logic              alu_src,
   input  logic [DATA_W-1:0] reg1_data,
   input  logic [DATA_W-1:0] reg2_data,
   input  logic [IMM_W-1:0]  immediate,
   input  logic [REG_AW-1:0] rd,
   input  logic [REG_AW-1:0] rt,
   input  logic [1:0]        reg_dst,
   input  logic [1:0]        forward_a,
   input  logic [1:0]        forward_b,
   input  logic [DATA_W-1:0] mem_forward_data,
   input  logic [DATA_W-1:0] wb_forward_data,
   output logic              out_valid,
   output logic [DATA_W-1:0] alu_result,
   output logic              zero_flag,
   output logic [REG_AW-1:0] write_reg_addr
);
   logic [DATA_W-1:0] imm_ext, op_a, fwd_b, op_b, alu_res;
   logic [REG_AW-1:0] dst_addr;
   logic              accept;

   logic              is_md, md_done;
   logic [DATA_W-1:0] md_result;
   logic [REG_AW-1:0] md_waddr;

   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] result_q, result_d;
   logic              zero_q, zero_d;
   logic [REG_AW-1:0] waddr_q, waddr_d;

   always_comb begin
      imm_ext = DATA_W'($signed(immediate));
      case (forward_a)
         2'b01:   op_a = mem_forward_data;
         2'b10:   op_a = wb_forward_data;
         default: op_a = reg1_data;
      endcase
      case (forward_b)
         2'b01:   fwd_b = mem_forward_data;
         2'b10:   fwd_b = wb_forward_data;
         default: fwd_b = reg2_data;
      endcase
      op_b = alu_src ? imm_ext : fwd_b;
      case (reg_dst)
         2'b00:   dst_addr = rd;
         2'b01:   dst_addr = rt;
         default: dst_addr = LINK_REG;
      endcase
   end

   alu #(.DATA_W(DATA_W)) u_alu (
      .op     (alu_op),
      .a      (op_a),
      .b      (op_b),
      .result (alu_res)
   );

   assign accept = in_valid & in_ready & ~flush;

`ifdef EX_MULDIV_EN
   localparam int CNT_W = $clog2(DATA_W + 1);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [3:0]        md_op_q, md_op_d;
   logic [DATA_W-1:0] md_a_q, md_a_d, md_b_q, md_b_d, md_acc_q, md_acc_d;
   logic [REG_AW-1:0] md_waddr_q, md_waddr_d;
   logic [DATA_W:0]   rem_sh;
   logic              md_start;

   assign is_md    = (alu_op == 4'hC) | (alu_op == 4'hD) | (alu_op == 4'hE);
   assign md_start = accept & is_md;
   assign md_waddr = md_waddr_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (flush) state_d = S_IDLE;
      else begin
         case (state_q)
            S_IDLE:  if (md_start) state_d = S_BUSY;
            S_BUSY:  if (cnt_q == CNT_W'(1)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      in_ready = (state_q == S_IDLE);
      md_done  = (state_q == S_DONE);
   end

   // md_a holds multiplicand/divisor; md_b is the shifting multiplier/quotient; md_acc is product/remainder
   always_comb begin
      cnt_d      = cnt_q;
      md_op_d    = md_op_q;
      md_a_d     = md_a_q;
      md_b_d     = md_b_q;
      md_acc_d   = md_acc_q;
      md_waddr_d = md_waddr_q;
      rem_sh     = {md_acc_q, md_b_q[DATA_W-1]};
      if (md_start) begin
         cnt_d      = CNT_W'(DATA_W);
         md_op_d    = alu_op;
         md_waddr_d = dst_addr;
         md_acc_d   = '0;
         if (alu_op == 4'hC) begin
            md_a_d = op_a;
            md_b_d = op_b;
         end else begin
            md_a_d = op_b;
            md_b_d = op_a;
         end
      end else if (state_q == S_BUSY) begin
         cnt_d = cnt_q - 1'b1;
         if (md_op_q == 4'hC) begin
            if (md_b_q[0]) md_acc_d = md_acc_q + md_a_q;
            md_a_d = md_a_q << 1;
            md_b_d = md_b_q >> 1;
         end else if (rem_sh >= {1'b0, md_a_q}) begin
            md_acc_d = DATA_W'(rem_sh - {1'b0, md_a_q});
            md_b_d   = {md_b_q[DATA_W-2:0], 1'b1};
         end else begin
            md_acc_d = rem_sh[DATA_W-1:0];
            md_b_d   = {md_b_q[DATA_W-2:0], 1'b0};
         end
      end
      md_result = (md_op_q == 4'hD) ? md_b_q : md_acc_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q      <= '0;
         md_op_q    <= '0;
         md_a_q     <= '0;
         md_b_q     <= '0;
         md_acc_q   <= '0;
         md_waddr_q <= '0;
      end else begin
         cnt_q      <= cnt_d;
         md_op_q    <= md_op_d;
         md_a_q     <= md_a_d;
         md_b_q     <= md_b_d;
         md_acc_q   <= md_acc_d;
         md_waddr_q <= md_waddr_d;
      end
   end
`else
   assign in_ready  = 1'b1;
   assign is_md     = 1'b0;
   assign md_done   = 1'b0;
   assign md_result = '0;
   assign md_waddr  = '0;
`endif

   always_comb begin
      out_valid_d = 1'b0;
      result_d    = result_q;
      zero_d      = zero_q;
      waddr_d     = waddr_q;
      if (flush) begin
         out_valid_d = 1'b0;
      end else if (accept && !is_md) begin
         out_valid_d = 1'b1;
         result_d    = alu_res;
         zero_d      = (alu_res == '0);
         waddr_d     = dst_addr;
      end else if (md_done) begin
         out_valid_d = 1'b1;
         result_d    = md_result;
         zero_d      = (md_result == '0);
         waddr_d     = md_waddr;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         result_q    <= '0;
         zero_q      <= 1'b0;
         waddr_q     <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         zero_q      <= zero_d;
         waddr_q     <= waddr_d;
      end
   end

   assign out_valid      = out_valid_q;
   assign alu_result     = result_q;
   assign zero_flag      = zero_q;
   assign write_reg_addr = waddr_q;
endmodule

// File: tb/tb_ex_stage_md.sv
// tb/tb_ex_stage_md.sv - randomized self-checking bench for ex_stage_md against an arithmetic reference model.
// Exercises the MD engine when EX_MULDIV_EN is defined, otherwise the single-cycle build.

module tb_ex_stage_md;
   logic        clk, rst, in_valid, in_ready, flush, alu_src;
   logic [3:0]  alu_op;
   logic [15:0] reg1_data, reg2_data, mem_forward_data, wb_forward_data, alu_result;
   logic [5:0]  immediate;
   logic [2:0]  rd, rt, write_reg_addr;
   logic [1:0]  reg_dst, forward_a, forward_b;
   logic        out_valid, zero_flag;

   int          checks = 0;
   int          errors = 0;
   int          ready_low = 0;
   logic [15:0] exp_res, last_res;
   logic [2:0]  exp_addr, last_addr;

   ex_stage_md #(.DATA_W(16), .IMM_W(6), .REG_AW(3)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
      .alu_op(alu_op), .alu_src(alu_src), .reg1_data(reg1_data), .reg2_data(reg2_data),
      .immediate(immediate), .rd(rd), .rt(rt), .reg_dst(reg_dst),
      .forward_a(forward_a), .forward_b(forward_b),
      .mem_forward_data(mem_forward_data), .wb_forward_data(wb_forward_data),
      .out_valid(out_valid), .alu_result(alu_result), .zero_flag(zero_flag),
      .write_reg_addr(write_reg_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (!rst && !in_ready) ready_low++;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] fwd_sel(input logic [1:0] sel, input logic [15:0] r, m, w);
      if (sel == 2'd1) return m;
      if (sel == 2'd2) return w;
      return r;
   endfunction

   function automatic logic [15:0] sext_imm(input logic [5:0] imm);
      int v;
      v = int'(imm);
      if (v >= 32) v = v - 64;
      return 16'(v);
   endfunction

   function automatic logic [15:0] alu_ref(input logic [3:0] op, input logic [15:0] a, b);
      int sh;
      sh = int'(b) % 16;
      case (op)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return a & b;
         4'd3:    return a | b;
         4'd4:    return a ^ b;
         4'd5:    return ~(a | b);
         4'd6:    return ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
         4'd7:    return (a < b) ? 16'd1 : 16'd0;
         4'd8:    return a << sh;
         4'd9:    return a >> sh;
         4'd10:   return 16'($signed(a) >>> sh);
         4'd11:   return b;
         default: return 16'd0;
      endcase
   endfunction

`ifdef EX_MULDIV_EN
   function automatic logic [15:0] md_ref(input logic [3:0] op, input logic [15:0] a, b);
      longint p;
      if (op == 4'hC) begin
         p = longint'(a) * longint'(b);
         return 16'(p % 65536);
      end
      if (b == 16'd0) return (op == 4'hD) ? 16'hFFFF : a;
      return (op == 4'hD) ? a / b : a % b;
   endfunction
`endif

   task automatic predict();
      logic [15:0] a, b;
      a = fwd_sel(forward_a, reg1_data, mem_forward_data, wb_forward_data);
      b = alu_src ? sext_imm(immediate) : fwd_sel(forward_b, reg2_data, mem_forward_data, wb_forward_data);
      exp_addr = (reg_dst == 2'd0) ? rd : (reg_dst == 2'd1) ? rt : 3'd7;
`ifdef EX_MULDIV_EN
      if (alu_op >= 4'hC && alu_op <= 4'hE) exp_res = md_ref(alu_op, a, b);
      else exp_res = alu_ref(alu_op, a, b);
`else
      exp_res = alu_ref(alu_op, a, b);
`endif
   endtask

   task automatic scramble(input int max_op);
      alu_op           = 4'($urandom_range(0, max_op));
      alu_src          = 1'($urandom);
      reg1_data        = 16'($urandom);
      reg2_data        = 16'($urandom);
      immediate        = 6'($urandom);
      rd               = 3'($urandom);
      rt               = 3'($urandom);
      reg_dst          = 2'($urandom);
      forward_a        = 2'($urandom);
      forward_b        = 2'($urandom);
      mem_forward_data = 16'($urandom);
      wb_forward_data  = 16'($urandom);
   endtask

   task automatic run_single(input string tag);
      predict();
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      check_eq({tag, ".valid"}, 32'(out_valid), 32'd1);
      check_eq({tag, ".result"}, 32'(alu_result), 32'(exp_res));
      check_eq({tag, ".zero"}, 32'(zero_flag), 32'(exp_res == 16'd0));
      check_eq({tag, ".waddr"}, 32'(write_reg_addr), 32'(exp_addr));
      check_eq({tag, ".ready"}, 32'(in_ready), 32'd1);
      last_res  = exp_res;
      last_addr = exp_addr;
   endtask

`ifdef EX_MULDIV_EN
   task automatic run_md(input string tag);
      int n, low;
      predict();
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      n = 0;
      low = 0;
      while (!out_valid && n < 40) begin
         if (!in_ready) low++;
         scramble(15);
         step();
         n++;
      end
      check_eq({tag, ".latency"}, 32'(n), 32'd17);
      check_eq({tag, ".ready_low"}, 32'(low), 32'd17);
      check_eq({tag, ".result"}, 32'(alu_result), 32'(exp_res));
      check_eq({tag, ".zero"}, 32'(zero_flag), 32'(exp_res == 16'd0));
      check_eq({tag, ".waddr"}, 32'(write_reg_addr), 32'(exp_addr));
      check_eq({tag, ".ready"}, 32'(in_ready), 32'd1);
      step();
      check_eq({tag, ".pulse"}, 32'(out_valid), 32'd0);
      check_eq({tag, ".hold"}, 32'(alu_result), 32'(exp_res));
      last_res  = exp_res;
      last_addr = exp_addr;
   endtask

   task automatic set_md(input logic [3:0] op, input logic [15:0] a, b);
      alu_op = op; alu_src = 1'b0; forward_a = 2'd0; forward_b = 2'd3;
      reg1_data = a; reg2_data = b; reg_dst = 2'd1; rt = 3'd5;
   endtask
`endif

   task automatic set_add_imm();
      alu_op = 4'd0; reg1_data = 16'h0005; immediate = 6'h3E; alu_src = 1'b1;
      reg_dst = 2'd0; rd = 3'd3; forward_a = 2'd0; forward_b = 2'd0;
   endtask

   initial begin
      int pulses;
      rst = 1'b1; in_valid = 1'b0; flush = 1'b0;
      scramble(11);
      step();
      step();
      check_eq("rst.valid", 32'(out_valid), 32'd0);
      check_eq("rst.result", 32'(alu_result), 32'd0);
      check_eq("rst.zero", 32'(zero_flag), 32'd0);
      check_eq("rst.waddr", 32'(write_reg_addr), 32'd0);
      check_eq("rst.ready", 32'(in_ready), 32'd1);
      rst = 1'b0;
      step();
      check_eq("idle0.valid", 32'(out_valid), 32'd0);

      set_add_imm();
      run_single("add_imm");
      check_eq("add_imm.value", 32'(alu_result), 32'h0003);

      alu_op = 4'd1; alu_src = 1'b0; reg1_data = 16'h1234; reg2_data = 16'h0034;
      forward_a = 2'd1; forward_b = 2'd2; mem_forward_data = 16'h0010; wb_forward_data = 16'h0010;
      run_single("sub_fwd");
      check_eq("sub_fwd.zero1", 32'(zero_flag), 32'd1);
      forward_a = 2'd3; forward_b = 2'd3;
      run_single("sub_reg");
      check_eq("sub_reg.value", 32'(alu_result), 32'h1200);

      step();
      check_eq("idle.valid", 32'(out_valid), 32'd0);
      check_eq("idle.hold", 32'(alu_result), 32'(last_res));
      check_eq("idle.hold_addr", 32'(write_reg_addr), 32'(last_addr));

      scramble(15);
      in_valid = 1'b1; flush = 1'b1;
      step();
      in_valid = 1'b0; flush = 1'b0;
      check_eq("flush_in.valid", 32'(out_valid), 32'd0);
      check_eq("flush_in.hold", 32'(alu_result), 32'(last_res));
      check_eq("flush_in.ready", 32'(in_ready), 32'd1);

`ifdef EX_MULDIV_EN
      for (int i = 0; i < 40; i++) begin
         scramble(11);
         run_single("rand_alu");
      end

      set_md(4'hC, 16'h0123, 16'h0045);
      run_md("mul");
      check_eq("mul.value", 32'(alu_result), 32'h4E6F);
      set_md(4'hD, 16'h00C8, 16'h0007);
      run_md("divu");
      check_eq("divu.value", 32'(alu_result), 32'h001C);
      set_md(4'hE, 16'h00C8, 16'h0007);
      run_md("remu");
      check_eq("remu.value", 32'(alu_result), 32'h0004);
      set_md(4'hD, 16'h00C8, 16'h0000);
      run_md("divu0");
      check_eq("divu0.value", 32'(alu_result), 32'hFFFF);
      set_md(4'hE, 16'h1234, 16'h0000);
      run_md("remu0");
      check_eq("remu0.value", 32'(alu_result), 32'h1234);

      for (int i = 0; i < 12; i++) begin
         scramble(15);
         alu_op = 4'(12 + (i % 3));
         if (i % 4 == 3) begin
            alu_src = 1'b0; forward_b = 2'd0; reg2_data = 16'($urandom_range(0, 15));
         end
         run_md("rand_md");
      end

      set_md(4'hC, 16'h0123, 16'h0045);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      repeat (4) step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      check_eq("flush_md.valid", 32'(out_valid), 32'd0);
      check_eq("flush_md.ready", 32'(in_ready), 32'd1);
      check_eq("flush_md.hold", 32'(alu_result), 32'(last_res));
      pulses = 0;
      repeat (20) begin
         step();
         if (out_valid) pulses++;
      end
      check_eq("flush_md.no_result", 32'(pulses), 32'd0);
      set_add_imm();
      run_single("flush_md.add");

      set_md(4'hC, 16'h0123, 16'h0045);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      repeat (4) step();
      rst = 1'b1;
      #1;
      check_eq("rst_md.ready", 32'(in_ready), 32'd1);
      check_eq("rst_md.valid", 32'(out_valid), 32'd0);
      check_eq("rst_md.result", 32'(alu_result), 32'd0);
      check_eq("rst_md.waddr", 32'(write_reg_addr), 32'd0);
      step();
      rst = 1'b0;
      pulses = 0;
      repeat (20) begin
         step();
         if (out_valid) pulses++;
      end
      check_eq("rst_md.no_result", 32'(pulses), 32'd0);
      set_add_imm();
      run_single("rst_md.add");
`else
      for (int i = 0; i < 40; i++) begin
         scramble(15);
         run_single("rand_alu");
      end
      scramble(11);
      alu_op = 4'hC;
      run_single("op_c");
      scramble(11);
      reg_dst = 2'd2;
      run_single("link");
      check_eq("link.value", 32'(write_reg_addr), 32'd7);
      check_eq("ready_const", 32'(ready_low), 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
